// File: rtl/poly_sample_player.sv
`default_nettype none
// poly_sample_player -- polyphonic one-shot sample player, saturating mixer, 1-bit sigma-delta output. Rev 1.0
// Build option VOICE_STEAL_EN: when every voice is busy, a new trigger steals the voice closest to finishing.
module poly_sample_player #(
  parameter int VOICES      = 4,
  parameter int SAMPLE_BITS = 3,
  parameter int ADDR_BITS   = 14,
  parameter int DATA_BITS   = 8,
  parameter int RATE_DIV    = 5000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [SAMPLE_BITS-1:0] SELECT,
  input  logic                   TRIGGER,
  output logic [SAMPLE_BITS-1:0] DESC_SEL,
  input  logic [ADDR_BITS-1:0]   DESC_START,
  input  logic [ADDR_BITS-1:0]   DESC_LEN,
  output logic [ADDR_BITS-1:0]   ROM_ADDR,
  input  logic [DATA_BITS-1:0]   ROM_DATA,
  output logic [VOICES-1:0]      VOICE_BUSY,
  output logic                   AUDIO
);
  localparam int DIV_W = $clog2(RATE_DIV);
  localparam int CNT_W = $clog2(VOICES + 1);
  localparam int ACC_W = DATA_BITS + $clog2(VOICES) + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [DATA_BITS-1:0] MID_LEVEL = {1'b1, {(DATA_BITS - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_MIX = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        fcnt_q, fcnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_BITS-1:0]    level_q, level_d;
  logic [DATA_BITS-1:0]    sd_q, sd_d;
  logic                    audio_q, audio_d;
  logic [ADDR_BITS-1:0]    rom_addr_q, rom_addr_d;
  logic                    pend_q, pend_d;
  logic [ADDR_BITS-1:0]    pend_start_q, pend_start_d;
  logic [ADDR_BITS-1:0]    pend_len_q, pend_len_d;
  logic [VOICES-1:0]       busy_q, busy_d;
  logic [ADDR_BITS-1:0]    ptr_q    [VOICES];
  logic [ADDR_BITS-1:0]    ptr_d    [VOICES];
  logic [ADDR_BITS-1:0]    remain_q [VOICES];
  logic [ADDR_BITS-1:0]    remain_d [VOICES];

  logic                    tick;
  logic                    serviced;
  logic                    any_free;
  logic [VOICES-1:0]       free_oh;
  logic [VOICES-1:0]       alloc_oh;
  logic signed [ACC_W-1:0] sample_s;
  logic [DATA_BITS-1:0]    clamp;

  // Offset-binary word to two's complement: flip the MSB, then sign-extend.
  assign sample_s = {{(ACC_W - DATA_BITS){~ROM_DATA[DATA_BITS-1]}},
                     ~ROM_DATA[DATA_BITS-1], ROM_DATA[DATA_BITS-2:0]};

  always_comb begin
    free_oh  = '0;
    any_free = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      if (!busy_q[v] && !any_free) begin
        free_oh[v] = 1'b1;
        any_free   = 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VOICES-1:0]    steal_oh;
  logic [ADDR_BITS-1:0] best_rem;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    steal_oh = VOICES'(1);
    best_rem = remain_q[0];
    for (int v = 1; v < VOICES; v++) begin
      if (remain_q[v] < best_rem) begin
        steal_oh    = '0;
        steal_oh[v] = 1'b1;
        best_rem    = remain_q[v];
      end
    end
  end

  always_comb begin
    alloc_oh = any_free ? free_oh : steal_oh;
  end
`else
  // With no free voice free_oh is zero, so the pending trigger is simply dropped.
  always_comb begin
    alloc_oh = free_oh;
  end
`endif

  always_comb begin
    clamp = acc_q[DATA_BITS-1:0];
    if (acc_q > SAT_HI) begin
      clamp = SAT_HI[DATA_BITS-1:0];
    end else if (acc_q < SAT_LO) begin
      clamp = SAT_LO[DATA_BITS-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    acc_d        = acc_q;
    level_d      = level_q;
    rom_addr_d   = rom_addr_q;
    pend_d       = pend_q;
    pend_start_d = pend_start_q;
    pend_len_d   = pend_len_q;
    busy_d       = busy_q;
    ptr_d        = ptr_q;
    remain_d     = remain_q;
    serviced     = 1'b0;

    tick  = (div_q == '0);
    div_d = (div_q == DIV_W'(RATE_DIV - 1)) ? '0 : div_q + 1'b1;
    {audio_d, sd_d} = {1'b0, sd_q} + {1'b0, level_q};

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d    = S_FETCH;
          fcnt_d     = '0;
          acc_d      = '0;
          rom_addr_d = ptr_q[0];
        end else if (pend_q) begin
          serviced = 1'b1;
          for (int v = 0; v < VOICES; v++) begin
            if (alloc_oh[v]) begin
              ptr_d[v]    = pend_start_q;
              remain_d[v] = pend_len_q;
              busy_d[v]   = 1'b1;
            end
          end
        end
      end
      S_FETCH: begin
        // ROM data for voice v arrives one cycle after its address, i.e. at fcnt = v+1.
        for (int v = 0; v < VOICES; v++) begin
          if ((fcnt_q == CNT_W'(v + 1)) && busy_q[v]) begin
            acc_d       = acc_q + sample_s;
            ptr_d[v]    = ptr_q[v] + 1'b1;
            remain_d[v] = remain_q[v] - 1'b1;
            if (remain_q[v] == ADDR_BITS'(1)) begin
              busy_d[v] = 1'b0;
            end
          end
        end
        for (int v = 1; v < VOICES; v++) begin
          if (fcnt_q == CNT_W'(v - 1)) begin
            rom_addr_d = ptr_q[v];
          end
        end
        if (fcnt_q == CNT_W'(VOICES)) begin
          state_d = S_MIX;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_MIX: begin
        level_d = {~clamp[DATA_BITS-1], clamp[DATA_BITS-2:0]};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh trigger wins over clearing the one just serviced.
    if (TRIGGER && (DESC_LEN != '0)) begin
      pend_d       = 1'b1;
      pend_start_d = DESC_START;
      pend_len_d   = DESC_LEN;
    end else if (serviced) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      fcnt_q       <= '0;
      acc_q        <= '0;
      level_q      <= MID_LEVEL;
      sd_q         <= '0;
      audio_q      <= 1'b0;
      rom_addr_q   <= '0;
      pend_q       <= 1'b0;
      pend_start_q <= '0;
      pend_len_q   <= '0;
      busy_q       <= '0;
      for (int v = 0; v < VOICES; v++) begin
        ptr_q[v]    <= '0;
        remain_q[v] <= '0;
      end
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      fcnt_q       <= fcnt_d;
      acc_q        <= acc_d;
      level_q      <= level_d;
      sd_q         <= sd_d;
      audio_q      <= audio_d;
      rom_addr_q   <= rom_addr_d;
      pend_q       <= pend_d;
      pend_start_q <= pend_start_d;
      pend_len_q   <= pend_len_d;
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      remain_q     <= remain_d;
    end
  end

  assign DESC_SEL   = SELECT;
  assign ROM_ADDR   = rom_addr_q;
  assign VOICE_BUSY = busy_q;
  assign AUDIO      = audio_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_sample_player.sv
`default_nettype none
// tb_poly_sample_player -- directed checks of allocation, fetch order, mixing, saturation and sigma-delta output.
// Levels are read through AUDIO: over any 256 cycles of constant level L the output carries exactly L ones.
module tb_poly_sample_player;
  localparam int VOICES = 4;
  localparam int SB     = 3;
  localparam int AB     = 14;
  localparam int DB     = 8;
  localparam int RATE   = 256;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [SB-1:0] SELECT;
  logic          TRIGGER;
  logic [SB-1:0] DESC_SEL;
  logic [AB-1:0] DESC_START;
  logic [AB-1:0] DESC_LEN;
  logic [AB-1:0] ROM_ADDR;
  logic [DB-1:0] ROM_DATA;
  logic [VOICES-1:0] VOICE_BUSY;
  logic          AUDIO;

  poly_sample_player #(
    .VOICES(VOICES), .SAMPLE_BITS(SB), .ADDR_BITS(AB), .DATA_BITS(DB), .RATE_DIV(RATE)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SELECT(SELECT), .TRIGGER(TRIGGER),
    .DESC_SEL(DESC_SEL), .DESC_START(DESC_START), .DESC_LEN(DESC_LEN),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .VOICE_BUSY(VOICE_BUSY), .AUDIO(AUDIO)
  );

  always #5 CLK = ~CLK;

  logic [DB-1:0] rom_mem [0:(1<<AB)-1];
  logic [DB-1:0] rom_q;
  always @(posedge CLK) rom_q <= rom_mem[ROM_ADDR];
  assign ROM_DATA = rom_q;

  int cyc   = 0;
  int ones  = 0;
  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end
  always @(posedge CLK) ones <= ones + int'(AUDIO);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Leaves the bench just after a tick edge (first FETCH cycle).
  task automatic to_tick();
    do step(1); while (cyc % RATE != 1);
  endtask

  // Leaves the bench in the cycle whose closing edge is a tick.
  task automatic to_pre_tick();
    do step(1); while (cyc % RATE != 0);
  endtask

  task automatic trig(input logic [AB-1:0] start, input logic [AB-1:0] len);
    SELECT     = SB'($urandom_range(0, 7));
    DESC_START = start;
    DESC_LEN   = len;
    TRIGGER    = 1'b1;
    step(1);
    TRIGGER    = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    int e;
    for (int a = 0; a < (1 << AB); a++) rom_mem[a] = 8'h80;
    for (int a = 0; a < 3; a++)  rom_mem[32'h100 + a] = 8'hC0;
    for (int a = 0; a < 10; a++) rom_mem[32'h200 + a] = 8'hFF;
    for (int a = 0; a < 10; a++) rom_mem[32'h300 + a] = 8'h00;

    RESET_N = 1'b0; TRIGGER = 1'b0; SELECT = '0; DESC_START = '0; DESC_LEN = '0;
    step(3);
    check_eq("rst_busy", 32'(VOICE_BUSY), 32'h0);
    check_eq("rst_rom_addr", 32'(ROM_ADDR), 32'h0);
    check_eq("rst_audio", 32'(AUDIO), 32'h0);
    SELECT = 3'd2;
    #1;
    check_eq("desc_sel", 32'(DESC_SEL), 32'h2);
    @(negedge CLK) RESET_N = 1'b1;

    // Single voice: three words of 0xC0 at 0x100
    to_tick();
    step(50);
    trig(14'h100, 14'd3);
    step(1);
    check_eq("single_busy", 32'(VOICE_BUSY), 32'h1);
    to_tick();
    check_eq("single_addr0", 32'(ROM_ADDR), 32'h100);
    step(10); s = ones;
    to_tick();
    check_eq("single_addr1", 32'(ROM_ADDR), 32'h101);
    step(10); e = ones;
    check_eq("single_level_c0", 32'(e - s), 32'd192);
    to_tick();
    check_eq("single_addr2", 32'(ROM_ADDR), 32'h102);
    check_eq("single_busy_last", 32'(VOICE_BUSY), 32'h1);
    step(6);
    check_eq("single_busy_done", 32'(VOICE_BUSY), 32'h0);
    to_tick();
    check_eq("single_addr3", 32'(ROM_ADDR), 32'h103);
    step(10); s = ones;
    to_tick();
    step(10); e = ones;
    check_eq("single_level_80", 32'(e - s), 32'd128);

    // Positive saturation: 4 x 0xFF
    for (int i = 0; i < 4; i++) trig(14'h200, 14'd10);
    step(1);
    check_eq("satp_busy", 32'(VOICE_BUSY), 32'hF);
    to_tick(); step(10); s = ones;
    to_tick(); step(10); e = ones;
    check_eq("satp_level_ff", 32'(e - s), 32'd255);
    repeat (8) to_tick();
    step(10);
    check_eq("satp_done", 32'(VOICE_BUSY), 32'h0);

    // Negative saturation: 4 x 0x00
    for (int i = 0; i < 4; i++) trig(14'h300, 14'd10);
    step(1);
    check_eq("satn_busy", 32'(VOICE_BUSY), 32'hF);
    to_tick(); step(10); s = ones;
    to_tick(); step(10); e = ones;
    check_eq("satn_level_00", 32'(e - s), 32'd0);
    repeat (8) to_tick();
    step(10);
    check_eq("satn_done", 32'(VOICE_BUSY), 32'h0);

    // Allocation: three back-to-back triggers each get a voice
    for (int i = 0; i < 3; i++) trig(14'h400, 14'd10);
    step(1);
    check_eq("alloc_busy", 32'(VOICE_BUSY), 32'h7);
    repeat (10) to_tick();
    step(10);
    check_eq("alloc_done", 32'(VOICE_BUSY), 32'h0);

    // Full: remain 9/4/4/7 then one more trigger
    trig(14'h1000, 14'd10);
    trig(14'h1100, 14'd5);
    trig(14'h1200, 14'd5);
    trig(14'h1300, 14'd8);
    step(1);
    check_eq("full_busy", 32'(VOICE_BUSY), 32'hF);
    to_tick();
    step(10);
    trig(14'h0500, 14'd3);
    step(2);
    check_eq("full_busy_after", 32'(VOICE_BUSY), 32'hF);
    to_tick();
    check_eq("full_ptr0", 32'(ROM_ADDR), 32'h1001);
    step(1);
`ifdef VOICE_STEAL_EN
    check_eq("full_ptr1", 32'(ROM_ADDR), 32'h0500);
`else
    check_eq("full_ptr1", 32'(ROM_ADDR), 32'h1101);
`endif
    step(1);
    check_eq("full_ptr2", 32'(ROM_ADDR), 32'h1201);
    step(1);
    check_eq("full_ptr3", 32'(ROM_ADDR), 32'h1301);
    repeat (8) to_tick();
    step(10);
    check_eq("full_done", 32'(VOICE_BUSY), 32'h0);

    // Triggers during FETCH: last non-empty one survives, LEN=0 is ignored
    to_tick();
    trig(14'h600, 14'd2);
    trig(14'h700, 14'd2);
    trig(14'h7F0, 14'd0);
    step(3);
    check_eq("fetch_trig_wait", 32'(VOICE_BUSY), 32'h0);
    step(1);
    check_eq("fetch_trig_alloc", 32'(VOICE_BUSY), 32'h1);
    to_tick();
    check_eq("fetch_trig_addr", 32'(ROM_ADDR), 32'h700);
    step(10);
    check_eq("fetch_trig_busy", 32'(VOICE_BUSY), 32'h1);
    to_tick();
    step(10);
    check_eq("fetch_trig_done", 32'(VOICE_BUSY), 32'h0);

    // Empty sample in IDLE
    trig(14'h800, 14'd0);
    step(2);
    check_eq("len0_busy", 32'(VOICE_BUSY), 32'h0);

    // Trigger in the tick cycle: allocated in the IDLE cycle after MIX
    to_pre_tick();
    trig(14'h900, 14'd4);
    step(6);
    check_eq("tick_trig_wait", 32'(VOICE_BUSY), 32'h0);
    step(1);
    check_eq("tick_trig_alloc", 32'(VOICE_BUSY), 32'h1);
    to_tick();
    check_eq("tick_trig_addr", 32'(ROM_ADDR), 32'h900);

    // Asynchronous reset mid-FETCH with voice 0 busy
    step(2);
    #3 RESET_N = 1'b0;
    #1;
    check_eq("arst_busy", 32'(VOICE_BUSY), 32'h0);
    check_eq("arst_audio", 32'(AUDIO), 32'h0);
    check_eq("arst_rom_addr", 32'(ROM_ADDR), 32'h0);
    @(negedge CLK) RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_eq("arst_duty", 32'(AUDIO), 32'(i % 2));
    end
    s = ones;
    step(256);
    e = ones;
    check_eq("arst_level_80", 32'(e - s), 32'd128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/poly_sample_player.md
Name: poly_sample_player

Overview:
- Next-generation, parametrised successor to the single-voice sample bank.
- Plays up to VOICES one-shot samples at once from a shared external sample ROM.
- Mixes the voices with saturation and drives a 1-bit first-order sigma-delta audio pin.
- Sits between the game controller (SELECT/TRIGGER) and the board audio output; also reports per-voice activity.

Parameters:
- VOICES, 4, number of simultaneous voices (1..8)
- SAMPLE_BITS, 3, width of sample selector
- ADDR_BITS, 14, sample ROM address width
- DATA_BITS, 8, sample width, unsigned offset-binary (0x80 = silence)
- RATE_DIV, 5000, CLK cycles per output sample (40 MHz / 5000 = 8 kHz); must be >= VOICES+3

Ports:
- CLK  in  1  system clock, 40 MHz
- RESET_N  in  1  asynchronous active-low reset
- SELECT  in  SAMPLE_BITS  sample to play, sampled with TRIGGER
- TRIGGER  in  1  one-cycle start request
- DESC_SEL  out  SAMPLE_BITS  descriptor lookup index (combinational copy of SELECT)
- DESC_START  in  ADDR_BITS  first ROM address of selected sample (combinational return)
- DESC_LEN  in  ADDR_BITS  sample length in words; 0 = empty sample
- ROM_ADDR  out  ADDR_BITS  sample ROM read address
- ROM_DATA  in  DATA_BITS  ROM read data, valid exactly 1 cycle after ROM_ADDR
- VOICE_BUSY  out  VOICES  bit v high while voice v is playing
- AUDIO  out  1  sigma-delta output

Behaviour:
- Reset (async, RESET_N low):
  - VOICE_BUSY=0, ROM_ADDR=0, AUDIO=0.
  - Mix level=0x80, sigma-delta accumulator=0.
  - Tick divider=0, pending trigger cleared.
- Tick divider: counts 0..RATE_DIV-1 and wraps; a tick occurs in the cycle the count is 0.
- Trigger capture:
  - When TRIGGER=1, latch {DESC_START, DESC_LEN} into a one-deep pending register.
  - A new trigger overwrites an unserviced pending one.
  - DESC_LEN=0 is discarded and never sets pending.
- States: IDLE, FETCH, MIX.
- IDLE:
  - If pending, allocate the lowest-index free voice: ptr=start, remain=len, busy=1. Clear pending. Takes 1 cycle.
  - If no voice is free, see the Optional Feature.
  - On a tick, go to FETCH with v=0. Tick wins over allocation in the same cycle; pending waits.
- FETCH (VOICES+1 cycles):
  - Cycle k<VOICES: ROM_ADDR=ptr[k].
  - Cycle k+1: if voice k busy, add (ROM_DATA ^ 0x80) as signed to the mix accumulator; then ptr+=1, remain-=1.
  - When remain reaches 0, busy clears after its last word is summed.
  - Idle voices contribute 0.
  - Accumulator width: DATA_BITS+clog2(VOICES)+1, signed, cleared on FETCH entry.
- MIX (1 cycle):
  - Clamp the accumulator to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
  - Mix level = clamp ^ 0x80, held until the next MIX.
  - Return to IDLE.
- Latency: a trigger serviced before tick T is audible in the level from MIX of tick T (≈VOICES+2 cycles after T).
- Sigma-delta: every CLK, {carry, acc} <= acc + level (DATA_BITS+1-bit add); AUDIO <= carry (registered).
- ptr wraps modulo 2^ADDR_BITS; no error is flagged.
- A trigger arriving during FETCH/MIX is held pending and serviced on return to IDLE.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: with all voices busy, the pending trigger reallocates the voice with the smallest remain (lowest index on ties). The stolen voice restarts immediately with the new sample.
- Undefined: with all voices busy, the pending trigger is dropped (pending cleared) and the voices are unaffected.

Test Plan:
- Reset: RESET_N low mid-FETCH with voice 0 busy -> immediately VOICE_BUSY=0, AUDIO=0; after release the level is 0x80 and AUDIO duty is 50% (alternating 0/1).
- Single voice: SELECT=2, DESC_START=0x100, DESC_LEN=3, ROM returns 0xC0 -> ROM_ADDR 0x100..0x102 on three successive ticks; level 0xC0 for 3 samples, then 0x80; VOICE_BUSY[0] falls after the third FETCH.
- Saturation: VOICES=4, all playing 0xFF -> sum 508 clamps to 127 -> level 0xFF; all 0x00 -> -512 clamps to -128 -> level 0x00.
- Allocation: 3 triggers with LEN=10 in consecutive cycles before a tick -> VOICE_BUSY=0b0111 once all are serviced (the third overwrites the second only if it arrives before the second is serviced; check with 2-cycle spacing).
- Full: 4 busy voices with remain 9/4/4/7, new trigger -> with VOICE_STEAL_EN, voice 1 restarts; without it, VOICE_BUSY and all ptrs are unchanged.
- Edge: DESC_LEN=0 trigger -> no voice allocated; trigger in the tick cycle -> allocated in the IDLE cycle after MIX, first played on the next tick.
